seq_divider_ctrl: RTL and testbench
===================================

Name: seq_divider_ctrl

Overview:
Sequential 32-bit unsigned restoring divider controller.
- Sits directly upstream of the shared 32-bit ALU and drives its src1/src2/funct each cycle.
- Consumes the ALU's result and carry to build quotient and remainder, one bit per cycle.
- Used as the divide unit in the unsigned complete divider.

Parameters:
- WIDTH, 32, operand width; fixed to 32 to match the ALU.
- CNT_W, 6, iteration counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a division; accepted only while ready=1.
- dividend  in  32  unsigned dividend; sampled when start is accepted.
- divisor  in  32  unsigned divisor; sampled when start is accepted.
- ready  out  1  high only in IDLE.
- valid  out  1  one-cycle pulse when quotient/remainder are final.
- quotient  out  32  result quotient; held until the next accepted start.
- remainder  out  32  result remainder; held until the next accepted start.
- div_zero  out  1  divide-by-zero flag (see Optional Feature).
- alu_src1  out  32  to ALU src1.
- alu_src2  out  32  to ALU src2.
- alu_funct  out  6  to ALU funct.
- alu_result  in  32  from ALU result.
- alu_carry  in  1  from ALU carry.

Behaviour:
Clock and reset:
- Single clock clk, rising edge. rst is synchronous and active-high.
- On reset: state=IDLE, quotient=0, remainder=0, valid=0, div_zero=0, counter=0, ready=1.
- rst during BUSY or DONE abandons the operation. Outputs return to reset values on the next edge and no valid pulse is issued.

States: IDLE, BUSY, DONE.
- IDLE: ready=1, alu_funct=6'b000000 (ALU outputs 0).
  - start=1 at edge k: latch divisor into dreg; Q<=dividend; R<=0; cnt<=0; go to BUSY.
- BUSY: ready=0, alu_funct=6'b001010 (SUB).
  - alu_src1 = {R[30:0], Q[31]} (shifted remainder, rs); alu_src2 = dreg.
  - ALU returns {carry,result} = rs - dreg. carry=1 means borrow (rs < dreg).
  - Each edge:
    - if alu_carry=0: R<=alu_result, Q<={Q[30:0],1}.
    - else: R<=rs, Q<={Q[30:0],0}.
    - cnt<=cnt+1.
  - R before each shift is < min(dreg, 2^31), so no bit is lost and carry alone decides.
  - After 32 iterations (cnt==31 on the edge) go to DONE.
- DONE: valid=1 for exactly one cycle; quotient=Q, remainder=R; next edge returns to IDLE.

Latency and handshake:
- start accepted at edge k → BUSY edges k+1..k+32 → valid high during the cycle after edge k+32 (33 cycles start-to-valid).
- start while ready=0 is ignored; in-flight operands are unaffected.
- start may be held high: a new division begins at the first IDLE cycle.
- quotient/remainder registers are written only at the BUSY→DONE transition, so they stay stable through the next operation until its DONE.

Optional Feature:
Macro: DIV_ZERO_CHK_EN
- Defined: on an accepted start with divisor==0, skip BUSY and go to DONE at the next edge.
  - quotient=32'hFFFFFFFF, remainder=dividend, div_zero=1 with valid.
  - div_zero is cleared on the next accepted start or reset.
  - Latency is 1 cycle.
- Undefined: divisor 0 runs the normal 32 iterations.
  - The result is naturally quotient=32'hFFFFFFFF, remainder=dividend.
  - div_zero is tied to 0.

Decomposition:
- Shared package div_pkg:
  - ALU funct constants FUNCT_ADD=6'b001001, FUNCT_SUB=6'b001010, FUNCT_NOP=6'b000000.
  - State encoding IDLE/BUSY/DONE.
  - WIDTH=32, ITER=32.
- One natural sub-module: div_iter_cnt, a CNT_W-bit counter with clear, enable and terminal-count output.
- The ALU stays external. A top-level wrapper instantiates this block plus the ALU.

Test Plan:
- dividend=100, divisor=7, start one cycle → valid exactly 33 cycles later; quotient=14, remainder=2; ready low throughout BUSY.
- dividend=32'hFFFFFFFF, divisor=32'hFFFFFFFE → quotient=1, remainder=1; dividend=5, divisor=9 → quotient=0, remainder=5.
- dividend=32'h12345678, divisor=0:
  - with DIV_ZERO_CHK_EN → valid 1 cycle later, quotient=32'hFFFFFFFF, remainder=32'h12345678, div_zero=1.
  - without the macro → same values after 33 cycles, div_zero=0.
- Start 100/7, pulse start with 50/5 at cycle 10 → second request ignored; result 14/2; start 50/5 again after IDLE → 10/0.
- Start 1000/3, assert rst at cycle 15 for one cycle → no valid pulse; next cycle outputs 0, ready=1; start 9/4 → quotient=2, remainder=1 after 33 cycles.
- Check alu_funct=SUB and alu_src2=divisor in every BUSY cycle, and alu_funct=0 in IDLE.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider controller and its surroundings.
//   - ALU funct encodings driven on alu_funct
//   - controller state encoding (plain localparams, legacy-compatible)
//   - datapath width and iteration count
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITER  = 32;
    localparam int unsigned DIV_CNT_W = 6;

    localparam logic [5:0] FUNCT_NOP = 6'b000000;
    localparam logic [5:0] FUNCT_ADD = 6'b001001;
    localparam logic [5:0] FUNCT_SUB = 6'b001010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Shift the next dividend bit into the partial remainder.
    function automatic logic [DIV_WIDTH-1:0] shift_rem(input logic [DIV_WIDTH-1:0] rem,
                                                       input logic              msb);
        return {rem[DIV_WIDTH-2:0], msb};
    endfunction

endpackage

// File: rtl/seq_divider_ctrl_if.sv
// Bundle of the divider's request/result handshake and its ALU connection.
//   start, dividend, divisor          : request side
//   ready, valid, quotient, remainder,
//   div_zero                          : status / result side
//   alu_src1, alu_src2, alu_funct     : divider -> ALU
//   alu_result, alu_carry             : ALU -> divider
// Modports:
//   slave  : the divider controller
//   master : requester plus ALU (drives requests and ALU outputs)
interface seq_divider_ctrl_if;
    import div_pkg::*;

    logic                 start;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 ready;
    logic                 valid;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 div_zero;
    logic [DIV_WIDTH-1:0] alu_src1;
    logic [DIV_WIDTH-1:0] alu_src2;
    logic [5:0]           alu_funct;
    logic [DIV_WIDTH-1:0] alu_result;
    logic                 alu_carry;

    modport slave (
        input  start, dividend, divisor, alu_result, alu_carry,
        output ready, valid, quotient, remainder, div_zero,
        output alu_src1, alu_src2, alu_funct
    );

    modport master (
        output start, dividend, divisor, alu_result, alu_carry,
        input  ready, valid, quotient, remainder, div_zero,
        input  alu_src1, alu_src2, alu_funct
    );

endinterface

// File: rtl/div_iter_cnt.sv
// Iteration counter for the divider: synchronous clear, count enable and a
// terminal-count flag that is high while the count equals ITER-1.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (count -> 0)
//   clr  : synchronous clear (count -> 0)
//   en   : increment enable
//   tc   : terminal count (count == ITER-1)
module div_iter_cnt #(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned ITER  = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/seq_divider_ctrl.sv
// Sequential 32-bit unsigned restoring divider controller. Drives the shared
// external ALU with a subtract each BUSY cycle and builds one quotient bit
// per cycle from the ALU borrow.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : seq_divider_ctrl_if.slave (request, result, ALU signals)
// Optional build macro:
//   DIV_ZERO_CHK_EN : divisor==0 finishes in one cycle with div_zero=1;
//                     when undefined, div_zero is tied low and divisor 0
//                     runs the normal 32 iterations.
module seq_divider_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,  // fixed to match the ALU
    parameter int unsigned CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    seq_divider_ctrl_if.slave   bus
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;          // working quotient / shifting dividend
    logic [WIDTH-1:0] r_q, r_d;          // partial remainder
    logic [WIDTH-1:0] dreg_q, dreg_d;    // latched divisor
    logic [WIDTH-1:0] res_q_q, res_q_d;  // published quotient
    logic [WIDTH-1:0] res_r_q, res_r_d;  // published remainder
    logic [WIDTH-1:0] rs;                // shifted remainder fed to the ALU
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
`ifdef DIV_ZERO_CHK_EN
    logic             dz_q, dz_d;
`endif

    div_iter_cnt #(
        .CNT_W (CNT_W),
        .ITER  (DIV_ITER)
    ) u_iter_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    // The partial remainder is always below 2^i after i steps, so its MSB is
    // zero before the shift and the ALU borrow alone decides each bit.
    assign rs     = shift_rem(r_q, q_q[WIDTH-1]);
    assign q_next = {q_q[WIDTH-2:0], ~bus.alu_carry};
    assign r_next = bus.alu_carry ? rs : bus.alu_result;

    always_comb begin
        state_d       = state_q;
        q_d           = q_q;
        r_d           = r_q;
        dreg_d        = dreg_q;
        res_q_d       = res_q_q;
        res_r_d       = res_r_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        bus.alu_src1  = '0;
        bus.alu_src2  = '0;
        bus.alu_funct = FUNCT_NOP;
`ifdef DIV_ZERO_CHK_EN
        dz_d          = dz_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dreg_d  = bus.divisor;
                    q_d     = bus.dividend;
                    r_d     = '0;
                    cnt_clr = 1'b1;
                    state_d = ST_BUSY;
`ifdef DIV_ZERO_CHK_EN
                    dz_d    = 1'b0;
                    if (bus.divisor == '0) begin
                        res_q_d = '1;
                        res_r_d = bus.dividend;
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_BUSY: begin
                bus.alu_funct = FUNCT_SUB;
                bus.alu_src1  = rs;
                bus.alu_src2  = dreg_q;
                cnt_en        = 1'b1;
                q_d           = q_next;
                r_d           = r_next;
                if (cnt_tc) begin
                    // Results are only published here so they stay stable
                    // while the next division is in flight.
                    res_q_d = q_next;
                    res_r_d = r_next;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            dreg_q  <= '0;
            res_q_q <= '0;
            res_r_q <= '0;
`ifdef DIV_ZERO_CHK_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dreg_q  <= dreg_d;
            res_q_q <= res_q_d;
            res_r_q <= res_r_d;
`ifdef DIV_ZERO_CHK_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.valid     = (state_q == ST_DONE);
    assign bus.quotient  = res_q_q;
    assign bus.remainder = res_r_q;
`ifdef DIV_ZERO_CHK_EN
    assign bus.div_zero  = dz_q;
`else
    assign bus.div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Scoreboard bench for seq_divider_ctrl with a behavioural ALU model.
module tb_seq_divider_ctrl;
    import div_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] dvs;
        logic        dz;
        int          lat;
        int          issue_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];

    seq_divider_ctrl_if bus ();

    seq_divider_ctrl #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: carry is the borrow of an unsigned subtract.
    always_comb begin
        logic [32:0] full;
        full = '0;
        case (bus.alu_funct)
            FUNCT_SUB: full = {1'b0, bus.alu_src1} - {1'b0, bus.alu_src2};
            FUNCT_ADD: full = {1'b0, bus.alu_src1} + {1'b0, bus.alu_src2};
            default:   full = '0;
        endcase
        bus.alu_result = full[31:0];
        bus.alu_carry  = full[32];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation on every valid and polices the ALU drive.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("quotient", bus.quotient, e.q);
                    chk("remainder", bus.remainder, e.r);
                    chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
                    chk("latency", cyc - e.issue_cyc, e.lat);
                end
            end else if (bus.ready) begin
                chk("idle_funct", {26'd0, bus.alu_funct}, {26'd0, FUNCT_NOP});
            end else begin
                chk("busy_funct", {26'd0, bus.alu_funct}, {26'd0, FUNCT_SUB});
                if (sbq.size() == 0) chk("busy_without_request", 32'd1, 32'd0);
                else chk("busy_src2", bus.alu_src2, sbq[0].dvs);
            end
        end
    end

    task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs,
                         input logic [31:0] q, input logic [31:0] r,
                         input logic dz, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dvs = dvs; e.dz = dz; e.lat = lat; e.issue_cyc = cyc;
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        sbq.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() > 0) begin
            chk("timeout", 32'd1, 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        int zlat;
        logic zdz;
`ifdef DIV_ZERO_CHK_EN
        zlat = 1;  zdz = 1'b1;
`else
        zlat = 33; zdz = 1'b0;
`endif
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        chk("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 100 / 7 with ready held low through BUSY
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        for (int i = 0; i < 31; i++) begin
            chk("busy_ready", {31'd0, bus.ready}, 32'd0);
            @(posedge clk); #1;
        end
        drain();

        issue(32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd1, 1'b0, 33);
        drain();
        issue(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
        drain();
        issue(32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, zdz, zlat);
        drain();

        // Start during BUSY is ignored; the latched divisor must stay 7.
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drain();
        issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);
        drain();

        // Reset mid-operation abandons it with no valid pulse.
        issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_valid", {31'd0, bus.valid}, 32'd0);
        chk("abort_quotient", bus.quotient, 32'd0);
        chk("abort_remainder", bus.remainder, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        issue(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 33);
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
